// File: rtl/alu_multicycle.sv
// alu_multicycle: per-thread ALU with a start/done handshake.
// Single-cycle ops (ADD/SUB/CMP/AND/OR/XOR) complete one enabled cycle after start.
// MUL (shift-add, LSB first) and DIV (restoring, MSB first) iterate for WIDTH RUN cycles.
// The result and done appear on the enabled cycle after the last RUN cycle.
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   enable        thread active; low freezes all state and masks done
//   start, op     operation request, sampled only in IDLE with enable high
//   rs, rt        operands, captured on an accepted start
//   busy          high during the WIDTH RUN cycles of MUL/DIV
//   done          one-cycle completion pulse
//   alu_out       registered result, held until the next done
//   div_by_zero   set with done of a DIV by zero, cleared on the next accepted start
module alu_multicycle #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    // The single-cycle work and the MUL/DIV finish both happen on the edge that
    // returns to IDLE, so the done cycle is already an IDLE cycle (back-to-back start).
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;      // MUL: shifted multiplicand; DIV: dividend / quotient shifter
    logic [WIDTH-1:0] b_q, b_d;      // MUL: shifted multiplier;   DIV: divisor
    logic [WIDTH-1:0] acc_q, acc_d;  // MUL: partial product;      DIV: partial remainder
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] quick_res;
    logic [WIDTH:0]   trial;
    logic             gt, lt;
    logic [2:0]       cmp_flags;

    // Result of single-cycle ops straight from the operand ports.
    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        if (SIGNED_CMP) begin
            gt = $signed(rs) > $signed(rt);
            lt = $signed(rs) < $signed(rt);
        end else begin
            gt = rs > rt;
            lt = rs < rt;
        end
        cmp_flags = {gt, rs == rt, lt};
        case (op)
            OP_ADD:  quick_res = rs + rt;
            OP_SUB:  quick_res = rs - rt;
            OP_CMP:  quick_res = WIDTH'(cmp_flags);
            OP_AND:  quick_res = rs & rt;
            OP_OR:   quick_res = rs | rt;
            OP_XOR:  quick_res = rs ^ rt;
            default: quick_res = '0;
        endcase
    end

    // Restoring-divide step: shift the next dividend bit into the remainder.
    assign trial = {acc_q, a_q[WIDTH-1]};

    // Next-state and datapath; everything holds while enable is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dz_d    = dz_q;

        if (enable) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d = op;
                        dz_d = 1'b0;
                        if (op == OP_MUL || op == OP_DIV) begin
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            a_d     = rs;
                            b_d     = rt;
                            acc_d   = '0;
                        end else begin
                            out_d  = quick_res;
                            done_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (op_q == OP_MUL) begin
                        acc_d = acc_q + (b_q[0] ? a_q : '0);
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end else if (trial >= {1'b0, b_q}) begin
                        acc_d = WIDTH'(trial - {1'b0, b_q});
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = trial[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        if (op_q == OP_MUL) begin
                            out_d = acc_d;
                        end else if (b_q == '0) begin
                            out_d = '1;
                        end else begin
                            out_d = a_d;
                        end
                        dz_d = (op_q == OP_DIV) && (b_q == '0);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // A done raised into a frozen cycle stays pending and shows on the first enabled cycle.
    assign done        = done_q & enable;
    assign busy        = busy_q;
    assign alu_out     = out_q;
    assign div_by_zero = dz_q;

endmodule
